quotient_bcd_conv: RTL and testbench
====================================

QUOTIENT_BCD_CONV -- requirements
Module: quotient_bcd_conv

Interface
REQ-001 SHALL have parameter N, default 32: width of the binary quotient integer part.
REQ-002 SHALL have parameter DIGITS, default 10: number of BCD output digits.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port valid_i, input, 1: upstream divider result valid.
REQ-006 SHALL have port y_int_i, input, N: unsigned integer part of the quotient from the divider.
REQ-007 SHALL have port ready_o, output, 1: block idle and able to accept a result.
REQ-008 SHALL have port bcd_o, output, 4*DIGITS: packed BCD result, digit 0 in bits [3:0].
REQ-009 SHALL have port valid_o, output, 1: bcd_o holds a completed conversion.
REQ-010 SHALL have port ready_i, input, 1: downstream display/consumer accepts bcd_o.

Function
REQ-011 SHALL implement an FSM with three states: IDLE, SHIFT and DONE.
REQ-012 SHALL drive ready_o=1 only in IDLE and valid_o=1 only in DONE, both registered.
REQ-013 SHALL, in IDLE on valid_i=1 (accept edge), latch y_int_i, clear the BCD register, load the shift counter with N, and enter SHIFT.
REQ-014 SHALL, on each SHIFT edge, add 3 to every BCD digit >=5, then shift {BCD, operand} left by one bit and decrement the counter (double-dabble).
REQ-015 SHALL perform exactly N shift edges and enter DONE on the Nth, so valid_o rises N cycles after the accept edge.
REQ-016 SHALL hold bcd_o and valid_o stable in DONE until ready_i=1, then return to IDLE on that edge.
REQ-017 SHALL, when valid_o and ready_i are both 1, transfer on that edge; the next accept occurs no earlier than the following edge.
REQ-018 SHALL ignore valid_i and y_int_i in SHIFT and DONE, with no effect on the conversion in progress.
REQ-019 SHALL keep bcd_o at its previous value in IDLE and SHIFT, updating it only on entry to DONE.
REQ-020 SHALL require DIGITS >= ceil(N*0.30103) and reject a violating configuration at elaboration.
REQ-021 SHALL treat y_int_i=0 as a normal conversion: N shift edges producing all-zero digits.

Reset
REQ-022 SHALL, when rst_i=0 at any time including mid-conversion, immediately force state=IDLE, ready_o=1, valid_o=0, bcd_o=0, counter=0 and the operand register=0.
REQ-023 SHALL start in IDLE on the first rising edge after rst_i returns to 1, and accept on that edge if valid_i=1.

Configuration
REQ-024 SHALL, with macro QUOT_BCD_BLANK_EN defined, add output port blank_o (output, DIGITS) with bit k=1 when digit k and every higher digit are 0, for k>=1; bit 0 is always 0.
REQ-025 SHALL update blank_o together with bcd_o and reset it to all ones except bit 0.
REQ-026 SHALL, without QUOT_BCD_BLANK_EN, omit the blank_o port and its logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover this case: N=32, y_int_i=1234 accepted with ready_i=1 -> valid_o high 32 cycles later, bcd_o digits 3..0 = 1,2,3,4 and the rest 0; blank_o (if enabled) = 10'b1111110000.
REQ-028 SHALL cover this case: y_int_i=32'hFFFFFFFF -> bcd_o = 4,2,9,4,9,6,7,2,9,5 (digit 9..0).
REQ-029 SHALL cover this case: y_int_i=0 -> bcd_o all zero, valid_o after 32 cycles, blank_o = 10'b1111111110.
REQ-030 SHALL cover this case: ready_i=0 held for 20 cycles in DONE -> bcd_o and valid_o stable; ready_i=1 -> IDLE next edge, ready_o=1.
REQ-031 SHALL cover this case: valid_i pulsed with 999 during SHIFT of 1234 -> result is still 1234, and 999 is never converted.
REQ-032 SHALL cover this case: rst_i=0 at shift 15 of a conversion -> outputs are reset values without waiting for a clock edge; a new accept of 7 after release yields bcd_o digit0=7.

Source files
------------

// File: rtl/quotient_bcd_conv.sv
// Sequential binary-to-BCD converter for a divider quotient (double-dabble, one bit per clock).
// Optional leading-zero blanking output is enabled by defining QUOT_BCD_BLANK_EN.
module quotient_bcd_conv #(
    parameter int N      = 32,
    parameter int DIGITS = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [N-1:0]        y_int_i,
    output logic                ready_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                valid_o,
    input  logic                ready_i,
`ifdef QUOT_BCD_BLANK_EN
    output logic [DIGITS-1:0]   blank_o,
`endif
    output logic [1:0]          dbg_state_o
);

    // Minimum digit count is ceil(N * log10(2)), evaluated in integer arithmetic.
    localparam int MIN_DIGITS = (N * 30103 + 99999) / 100000;
    localparam int CW         = $clog2(N + 1);

    generate
        if (DIGITS < MIN_DIGITS) begin : g_bad_digits
            $error("quotient_bcd_conv: DIGITS too small for N");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [N-1:0]        r_op;
    logic [4*DIGITS-1:0] r_bcd;
    logic [4*DIGITS-1:0] r_bcd_out;
    logic [CW-1:0]       r_cnt;
    logic                r_ready;
    logic                r_valid;
    logic [4*DIGITS-1:0] w_adj;
    logic [4*DIGITS-1:0] w_shift_bcd;
    logic                w_accept;
    logic                w_last;

    // Handshake: input transfer when valid_i && ready_o, output transfer when valid_o && ready_i.
    assign w_accept = (r_state == S_IDLE) && valid_i;
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (valid_i) w_next_state = S_SHIFT;
            S_SHIFT: if (r_cnt == CW'(1)) w_next_state = S_DONE;
            S_DONE:  if (ready_i) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_shift_bcd = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_op[N-1]};
    end

`ifdef QUOT_BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank;
    logic              v_zero;

    // A digit blanks only when it and every more significant digit are zero.
    always_comb begin
        w_blank = '0;
        v_zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            v_zero     = v_zero && (w_shift_bcd[4*k +: 4] == 4'd0);
            w_blank[k] = v_zero;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_blank <= ~DIGITS'(1);
        end else if (w_last) begin
            r_blank <= w_blank;
        end
    end

    assign blank_o = r_blank;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_op      <= '0;
            r_bcd     <= '0;
            r_bcd_out <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= y_int_i;
                r_bcd <= '0;
                r_cnt <= CW'(N);
            end else if (r_state == S_SHIFT) begin
                r_op  <= r_op << 1;
                r_bcd <= w_shift_bcd;
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_last) begin
                r_bcd_out <= w_shift_bcd;
            end
            r_ready <= (w_next_state == S_IDLE);
            r_valid <= (w_next_state == S_DONE);
        end
    end

    assign ready_o     = r_ready;
    assign valid_o     = r_valid;
    assign bcd_o       = r_bcd_out;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_quotient_bcd_conv.sv
// Table-driven bench for quotient_bcd_conv with an expected-result queue and reset/handshake corner cases.
module tb_quotient_bcd_conv;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] y_int_i;
    logic        ready_o;
    logic [39:0] bcd_o;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  dbg_state_o;
`ifdef QUOT_BCD_BLANK_EN
    logic [9:0]  blank_o;
`endif

    quotient_bcd_conv #(.N(32), .DIGITS(10)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .y_int_i     (y_int_i),
        .ready_o     (ready_o),
        .bcd_o       (bcd_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
`ifdef QUOT_BCD_BLANK_EN
        .blank_o     (blank_o),
`endif
        .dbg_state_o (dbg_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          errors = 0;
    int          checks = 0;
    logic [39:0] exp_q[$];
    logic [39:0] prev_exp;

    typedef struct {
        logic [31:0] y;
        logic [39:0] bcd;
        int          hold;
        bit          inject;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        logic [39:0]     r;
        longint unsigned x;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

`ifdef QUOT_BCD_BLANK_EN
    function automatic logic [9:0] blank_of(input logic [39:0] b);
        logic [9:0] r;
        r = '0;
        for (int k = 1; k < 10; k++) begin
            r[k] = ((b >> (4*k)) == 40'd0);
        end
        return r;
    endfunction
`endif

    task automatic convert(input logic [31:0] y, input logic [39:0] exp, input int hold, input bit inject);
        int          lat;
        int          waitc;
        logic [39:0] e;
        bit          stable;
        waitc = 0;
        while (!ready_o && waitc < 50) begin
            @(negedge clk_i);
            waitc++;
        end
        chk("ready_in_idle", ready_o, 1);
        valid_i = 1'b1;
        y_int_i = y;
        exp_q.push_back(exp);
        @(negedge clk_i);
        valid_i = 1'b0;
        y_int_i = $urandom;
        chk("shift_ready_low", ready_o, 0);
        chk("shift_bcd_held", bcd_o, prev_exp);
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(negedge clk_i);
            lat++;
            if (inject && lat == 5) begin
                valid_i = 1'b1;
                y_int_i = 32'd999;
            end else begin
                valid_i = 1'b0;
            end
        end
        valid_i = 1'b0;
        chk("latency", lat, 32);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '1;
        chk("bcd", bcd_o, e);
        chk("done_ready_low", ready_o, 0);
`ifdef QUOT_BCD_BLANK_EN
        chk("blank", blank_o, blank_of(e));
`endif
        prev_exp = e;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk_i);
            if (bcd_o !== e || valid_o !== 1'b1) stable = 1'b0;
        end
        chk("done_stable", stable, 1);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        chk("idle_valid_low", valid_o, 0);
        chk("idle_ready_high", ready_o, 1);
        chk("idle_state", dbg_state_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'd1234,       40'h0000001234, 0,  1'b0};
        vecs[1] = '{32'hFFFFFFFF,   40'h4294967295, 2,  1'b0};
        vecs[2] = '{32'd0,          40'h0000000000, 0,  1'b0};
        vecs[3] = '{32'd1234,       40'h0000001234, 20, 1'b1};
        vecs[4] = '{32'd99999999,   40'h0099999999, 1,  1'b0};
        vecs[5] = '{32'd1000000000, 40'h1000000000, 0,  1'b0};
        vecs[6] = '{32'd5,          40'h0000000005, 3,  1'b0};
        vecs[7] = '{32'd4000000009, 40'h4000000009, 0,  1'b0};

        rst_i    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        y_int_i  = '0;
        prev_exp = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_bcd", bcd_o, 0);
        chk("rst_state", dbg_state_o, 0);
`ifdef QUOT_BCD_BLANK_EN
        chk("rst_blank", blank_o, 10'b1111111110);
`endif
        rst_i = 1'b1;

        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].y, vecs[i].bcd, vecs[i].hold, vecs[i].inject);
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] r;
            r = $urandom;
            convert(r, to_bcd(r), $urandom_range(0, 3), 1'b0);
        end

        // Asynchronous reset in the middle of a conversion, then restart.
        valid_i = 1'b1;
        y_int_i = 32'd1234;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (15) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("midrst_ready", ready_o, 1);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_bcd", bcd_o, 0);
        chk("midrst_state", dbg_state_o, 0);
        prev_exp = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        convert(32'd7, 40'h0000000007, 0, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
